// File: rtl/motion_step_scheduler_if.sv
// motion_step_scheduler_if: request, preload and step-output bundle between motion controller and scheduler
interface motion_step_scheduler_if;
    logic        en;
    logic        theta_pos;
    logic        theta_neg;
    logic        phi_pos;
    logic        phi_neg;
    logic        load;
    logic [15:0] load_theta;
    logic [15:0] load_phi;
    logic        step_theta;
    logic        step_phi;
    logic        dir_theta;
    logic        dir_phi;
    logic [15:0] pos_theta;
    logic [15:0] pos_phi;
    logic        busy;
    logic        limit_hit;
    modport master (
        output en, theta_pos, theta_neg, phi_pos, phi_neg, load, load_theta, load_phi,
        input  step_theta, step_phi, dir_theta, dir_phi, pos_theta, pos_phi, busy, limit_hit
    );
    modport slave (
        input  en, theta_pos, theta_neg, phi_pos, phi_neg, load, load_theta, load_phi,
        output step_theta, step_phi, dir_theta, dir_phi, pos_theta, pos_phi, busy, limit_hit
    );
endinterface

// File: rtl/motion_step_scheduler.sv
// motion_step_scheduler: round-robin single-motor step pulse generator with clamped position counters
module motion_step_scheduler #(
    parameter int          DIR_SETUP = 2,
    parameter int          STEP_HIGH = 50,
    parameter int          STEP_GAP  = 1000,
    parameter logic [15:0] POS_MAX   = 16'hFFFF
) (
    input logic                    clk,
    input logic                    rst_n,
    motion_step_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;
    state_t      state;
    logic [31:0] cnt;
    logic        sel_phi, dir_sel, last_phi;
    logic        th_req, th_lim, th_ok, ph_req, ph_lim, ph_ok, grant_phi;
    function automatic logic [15:0] clamp(input logic [15:0] v);
        return v > POS_MAX ? POS_MAX : v;
    endfunction
    always_comb begin
        th_req    = bus.theta_pos ^ bus.theta_neg;
        th_lim    = th_req && (bus.theta_pos ? bus.pos_theta == POS_MAX : bus.pos_theta == 16'd0);
        th_ok     = th_req && !th_lim;
        ph_req    = bus.phi_pos ^ bus.phi_neg;
        ph_lim    = ph_req && (bus.phi_pos ? bus.pos_phi == POS_MAX : bus.pos_phi == 16'd0);
        ph_ok     = ph_req && !ph_lim;
        grant_phi = ph_ok && (!th_ok || !last_phi);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            sel_phi        <= 1'b0;
            dir_sel        <= 1'b0;
            last_phi       <= 1'b1;
            bus.step_theta <= 1'b0;
            bus.step_phi   <= 1'b0;
            bus.dir_theta  <= 1'b0;
            bus.dir_phi    <= 1'b0;
            bus.pos_theta  <= '0;
            bus.pos_phi    <= '0;
            bus.busy       <= 1'b0;
            bus.limit_hit  <= 1'b0;
        end else begin
            bus.limit_hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        bus.pos_theta <= clamp(bus.load_theta);
                        bus.pos_phi   <= clamp(bus.load_phi);
                    end else if (bus.en) begin
                        bus.limit_hit <= th_lim || ph_lim;
                        if (th_ok || ph_ok) begin
                            sel_phi  <= grant_phi;
                            dir_sel  <= grant_phi ? bus.phi_pos : bus.theta_pos;
                            if (grant_phi) bus.dir_phi <= bus.phi_pos;
                            else bus.dir_theta <= bus.theta_pos;
                            bus.busy <= 1'b1;
                            cnt      <= 32'(DIR_SETUP - 1);
                            state    <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= PULSE;
                        cnt   <= 32'(STEP_HIGH - 1);
                        if (sel_phi) bus.step_phi <= 1'b1;
                        else bus.step_theta <= 1'b1;
                    end else cnt <= cnt - 1;
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state          <= GAP;
                        cnt            <= 32'(STEP_GAP - 1);
                        bus.step_theta <= 1'b0;
                        bus.step_phi   <= 1'b0;
                        // limits were checked at grant, so +/-1 cannot wrap
                        if (sel_phi) bus.pos_phi <= dir_sel ? bus.pos_phi + 16'd1 : bus.pos_phi - 16'd1;
                        else bus.pos_theta <= dir_sel ? bus.pos_theta + 16'd1 : bus.pos_theta - 16'd1;
                    end else cnt <= cnt - 1;
                end
                GAP: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        last_phi <= sel_phi;
                    end else cnt <= cnt - 1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_motion_step_scheduler.sv
// tb_motion_step_scheduler: randomized and directed checks against a cycles-since-grant reference model
module tb_motion_step_scheduler;
    localparam int          DS = 2;
    localparam int          SH = 3;
    localparam int          SG = 4;
    localparam logic [15:0] PM = 16'd10;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    motion_step_scheduler_if ifc ();
    motion_step_scheduler #(.DIR_SETUP(DS), .STEP_HIGH(SH), .STEP_GAP(SG), .POS_MAX(PM)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
    );
    always #5 clk = ~clk;

    // Model: k counts cycles since the grant edge (0 = idle); outputs follow from k by arithmetic.
    int          k = 0;
    logic        m_ax = 1'b0, m_d = 1'b0, m_lastp = 1'b1;
    logic        m_st_t = 1'b0, m_st_p = 1'b0, m_dir_t = 1'b0, m_dir_p = 1'b0, m_busy = 1'b0, m_lim = 1'b0;
    logic [15:0] m_pos_t = '0, m_pos_p = '0;
    logic        t_raw, t_blk, t_ok, p_raw, p_blk, p_ok;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; m_ax = 0; m_d = 0; m_lastp = 1;
            m_st_t = 0; m_st_p = 0; m_dir_t = 0; m_dir_p = 0; m_busy = 0; m_lim = 0;
            m_pos_t = 0; m_pos_p = 0;
        end else begin
            m_lim = 0;
            if (k == 0) begin
                if (ifc.load) begin
                    m_pos_t = (ifc.load_theta > PM) ? PM : ifc.load_theta;
                    m_pos_p = (ifc.load_phi > PM) ? PM : ifc.load_phi;
                end else if (ifc.en) begin
                    t_raw = ifc.theta_pos != ifc.theta_neg;
                    t_blk = t_raw && (ifc.theta_pos ? m_pos_t == PM : m_pos_t == 0);
                    t_ok  = t_raw && !t_blk;
                    p_raw = ifc.phi_pos != ifc.phi_neg;
                    p_blk = p_raw && (ifc.phi_pos ? m_pos_p == PM : m_pos_p == 0);
                    p_ok  = p_raw && !p_blk;
                    m_lim = t_blk || p_blk;
                    if (t_ok || p_ok) begin
                        m_ax = (t_ok && p_ok) ? !m_lastp : p_ok;
                        m_d  = m_ax ? ifc.phi_pos : ifc.theta_pos;
                        if (m_ax) m_dir_p = m_d; else m_dir_t = m_d;
                        k = 1;
                    end
                end
            end else begin
                k++;
                if (k == DS + SH + 1) begin
                    if (m_ax) m_pos_p = m_d ? m_pos_p + 16'd1 : m_pos_p - 16'd1;
                    else m_pos_t = m_d ? m_pos_t + 16'd1 : m_pos_t - 16'd1;
                end
                if (k == DS + SH + SG + 1) begin
                    k = 0;
                    m_lastp = m_ax;
                end
            end
            m_busy = k != 0;
            m_st_t = !m_ax && k > DS && k <= DS + SH;
            m_st_p = m_ax && k > DS && k <= DS + SH;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("outputs", 64'({ifc.step_theta, ifc.step_phi, ifc.dir_theta, ifc.dir_phi, ifc.busy, ifc.limit_hit, ifc.pos_theta, ifc.pos_phi}),
                       64'({m_st_t, m_st_p, m_dir_t, m_dir_p, m_busy, m_lim, m_pos_t, m_pos_p}));
        if (ifc.step_theta && ifc.step_phi) chk("exclusive_steps", 64'(1), 64'(0));
    end

    task automatic idle_inputs();
        ifc.en = 0; ifc.theta_pos = 0; ifc.theta_neg = 0; ifc.phi_pos = 0; ifc.phi_neg = 0;
        ifc.load = 0; ifc.load_theta = 0; ifc.load_phi = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    int n, cnt;
    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk("reset_state", 64'({ifc.step_theta, ifc.step_phi, ifc.dir_theta, ifc.dir_phi, ifc.busy, ifc.limit_hit, ifc.pos_theta, ifc.pos_phi}), 64'(0));

        // theta_pos held from reset: pos_theta reaches 10 after 96 edges, then limit_hit every idle cycle
        ifc.en = 1; ifc.theta_pos = 1;
        n = 0;
        while (n < 300 && ifc.pos_theta != 16'd10) begin
            @(negedge clk);
            n++;
        end
        chk("edges_to_pos10", 64'(n), 64'(96));
        chk("dir_theta_pos", 64'(ifc.dir_theta), 64'(1));
        repeat (5) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cnt += int'(ifc.limit_hit) + 2 * int'(ifc.step_theta) + 2 * int'(ifc.busy);
            @(negedge clk);
        end
        chk("limit_hit_repeats", 64'(cnt), 64'(5));

        // load clamps above POS_MAX
        idle_inputs();
        @(negedge clk);
        ifc.load = 1; ifc.load_theta = 16'h0020; ifc.load_phi = 16'd3;
        @(negedge clk);
        ifc.load = 0;
        chk("load_clamp", 64'(ifc.pos_theta), 64'(10));
        chk("load_phi", 64'(ifc.pos_phi), 64'(3));

        // both directions on one axis: no request, no limit
        ifc.en = 1; ifc.theta_pos = 1; ifc.theta_neg = 1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt += int'(ifc.busy) + int'(ifc.limit_hit);
        end
        chk("both_dirs_ignored", 64'(cnt), 64'(0));

        // alternating grants theta, phi, theta, phi
        do_reset();
        ifc.load = 1; ifc.load_phi = 16'd5;
        @(negedge clk);
        ifc.load = 0; ifc.en = 1; ifc.theta_pos = 1; ifc.phi_neg = 1;
        repeat (40) @(negedge clk);
        chk("alt_pos_theta", 64'(ifc.pos_theta), 64'(2));
        chk("alt_pos_phi", 64'(ifc.pos_phi), 64'(3));
        chk("alt_dir_phi", 64'(ifc.dir_phi), 64'(0));

        // request dropped after grant: step still completes, busy spans 9 cycles
        do_reset();
        ifc.en = 1; ifc.phi_pos = 1;
        @(negedge clk);
        ifc.phi_pos = 0;
        cnt = int'(ifc.busy);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            cnt += int'(ifc.busy);
        end
        chk("busy_span", 64'(cnt), 64'(9));
        chk("dropped_step_pos", 64'(ifc.pos_phi), 64'(1));

        // load during PULSE is ignored
        do_reset();
        ifc.en = 1; ifc.theta_pos = 1;
        repeat (4) @(negedge clk);
        chk("in_pulse", 64'(ifc.step_theta), 64'(1));
        ifc.load = 1; ifc.load_theta = 16'd7;
        @(negedge clk);
        ifc.load = 0;
        chk("load_ignored", 64'(ifc.pos_theta), 64'(0));
        @(negedge clk);
        chk("pos_after_pulse", 64'(ifc.pos_theta), 64'(1));

        // async reset during PULSE
        do_reset();
        ifc.en = 1; ifc.theta_pos = 1;
        repeat (4) @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst_mid_pulse", 64'({ifc.step_theta, ifc.busy, ifc.pos_theta}), 64'(0));
        @(negedge clk);
        rst_n = 1;
        repeat (10) @(negedge clk);
        chk("resume_after_rst", 64'(ifc.pos_theta), 64'(1));

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ifc.en = ($urandom % 8) != 0;
            if ($urandom % 6 == 0) begin
                ifc.theta_pos = 1'($urandom); ifc.theta_neg = 1'($urandom);
                ifc.phi_pos = 1'($urandom); ifc.phi_neg = 1'($urandom);
            end
            ifc.load = ($urandom % 25) == 0;
            ifc.load_theta = 16'($urandom_range(0, 14));
            ifc.load_phi = ($urandom % 10 == 0) ? 16'($urandom) : 16'($urandom_range(0, 10));
        end
        idle_inputs();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
